// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: two cache miss ports plus the shared memory handshake.
// The arbiter uses the slave view; the caches and memory model use master.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                  req_valid_0, req_write_0, req_ready_0, resp_valid_0;
    logic [ADDR_WIDTH-1:0] req_addr_0;
    logic [LINE_WIDTH-1:0] req_wdata_0, resp_rdata_0;
    logic                  req_valid_1, req_write_1, req_ready_1, resp_valid_1;
    logic [ADDR_WIDTH-1:0] req_addr_1;
    logic [LINE_WIDTH-1:0] req_wdata_1, resp_rdata_1;
    logic                  mem_is_input_valid, mem_read, mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0] mem_din, mem_dout;
    logic                  mem_is_ready, mem_is_output_valid, busy;

    modport slave (
        input  req_valid_0, req_write_0, req_addr_0, req_wdata_0,
        input  req_valid_1, req_write_1, req_addr_1, req_wdata_1,
        input  mem_is_ready, mem_is_output_valid, mem_dout,
        output req_ready_0, resp_valid_0, resp_rdata_0,
        output req_ready_1, resp_valid_1, resp_rdata_1,
        output mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din, busy
    );

    modport master (
        output req_valid_0, req_write_0, req_addr_0, req_wdata_0,
        output req_valid_1, req_write_1, req_addr_1, req_wdata_1,
        output mem_is_ready, mem_is_output_valid, mem_dout,
        input  req_ready_0, resp_valid_0, resp_rdata_0,
        input  req_ready_1, resp_valid_1, resp_rdata_1,
        input  mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one multi-cycle memory port between
// the I-cache (port 0) and D-cache (port 1), one transaction in flight.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t                state;
    logic                  owner, last_grant, lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [LINE_WIDTH-1:0] lat_wdata, rdata;
    logic                  sel, accept, issuing;

    // a tie goes to the port that did not win the previous grant
    assign sel     = bus.req_valid_0 && bus.req_valid_1 ? ~last_grant : bus.req_valid_1;
    assign accept  = reset && state == IDLE && (bus.req_valid_0 || bus.req_valid_1);
    assign issuing = state == ISSUE;

    assign bus.req_ready_0        = accept && !sel;
    assign bus.req_ready_1        = accept && sel;
    assign bus.mem_is_input_valid = issuing;
    assign bus.mem_read           = issuing && !lat_write;
    assign bus.mem_write          = issuing && lat_write;
    assign bus.mem_addr           = issuing ? lat_addr : '0;
    assign bus.mem_din            = issuing && lat_write ? lat_wdata : '0;
    assign bus.resp_valid_0       = state == RESP && !owner;
    assign bus.resp_valid_1       = state == RESP && owner;
    assign bus.resp_rdata_0       = bus.resp_valid_0 && !lat_write ? rdata : '0;
    assign bus.resp_rdata_1       = bus.resp_valid_1 && !lat_write ? rdata : '0;
    assign bus.busy               = state != IDLE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state      <= ISSUE;
                    owner      <= sel;
                    last_grant <= sel;
                    lat_write  <= sel ? bus.req_write_1 : bus.req_write_0;
                    lat_addr   <= sel ? bus.req_addr_1 : bus.req_addr_0;
                    lat_wdata  <= sel ? bus.req_wdata_1 : bus.req_wdata_0;
                end
                ISSUE: if (bus.mem_is_ready) state <= lat_write ? RESP : WAIT;
                WAIT: if (bus.mem_is_output_valid) begin
                    rdata <= bus.mem_dout;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic checking = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {127'd0, act}, {127'd0, exp});
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // model: at most one transaction; tracks whether memory took it and whether a reply is due
    logic         m_active = 1'b0, m_issued = 1'b0, m_resp = 1'b0, m_last = 1'b1;
    logic         m_port = 1'b0, m_write = 1'b0;
    logic [31:0]  m_addr = '0;
    logic [127:0] m_wdata = '0, m_rdata = '0;
    logic         m_idle, e_rdy0, e_rdy1, e_miv, e_rv0, e_rv1;

    assign m_idle = !m_active && !m_resp;
    assign e_rdy0 = reset && m_idle && bus.req_valid_0 && (!bus.req_valid_1 || m_last);
    assign e_rdy1 = reset && m_idle && bus.req_valid_1 && (!bus.req_valid_0 || !m_last);
    assign e_miv  = m_active && !m_issued;
    assign e_rv0  = m_resp && !m_port;
    assign e_rv1  = m_resp && m_port;

    always @(posedge clk) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_resp   <= 1'b0;
            m_last   <= 1'b1;
        end else if (m_resp) begin
            m_resp <= 1'b0;
        end else if (m_idle) begin
            if (e_rdy0 || e_rdy1) begin
                m_active <= 1'b1;
                m_issued <= 1'b0;
                m_port   <= e_rdy1;
                m_last   <= e_rdy1;
                m_write  <= e_rdy1 ? bus.req_write_1 : bus.req_write_0;
                m_addr   <= e_rdy1 ? bus.req_addr_1 : bus.req_addr_0;
                m_wdata  <= e_rdy1 ? bus.req_wdata_1 : bus.req_wdata_0;
            end
        end else if (!m_issued) begin
            if (bus.mem_is_ready) begin
                if (m_write) begin
                    m_active <= 1'b0;
                    m_resp   <= 1'b1;
                    m_rdata  <= '0;
                end else begin
                    m_issued <= 1'b1;
                end
            end
        end else if (bus.mem_is_output_valid) begin
            m_active <= 1'b0;
            m_resp   <= 1'b1;
            m_rdata  <= bus.mem_dout;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chkb("req_ready_0", bus.req_ready_0, e_rdy0);
            chkb("req_ready_1", bus.req_ready_1, e_rdy1);
            chkb("mem_is_input_valid", bus.mem_is_input_valid, e_miv);
            chkb("mem_read", bus.mem_read, e_miv && !m_write);
            chkb("mem_write", bus.mem_write, e_miv && m_write);
            chk("mem_addr", 128'(bus.mem_addr), e_miv ? 128'(m_addr) : 128'd0);
            chk("mem_din", bus.mem_din, e_miv && m_write ? m_wdata : 128'd0);
            chkb("resp_valid_0", bus.resp_valid_0, e_rv0);
            chkb("resp_valid_1", bus.resp_valid_1, e_rv1);
            chk("resp_rdata_0", bus.resp_rdata_0, e_rv0 ? m_rdata : 128'd0);
            chk("resp_rdata_1", bus.resp_rdata_1, e_rv1 ? m_rdata : 128'd0);
            chkb("busy", bus.busy, m_active || m_resp);
        end
    end

    logic [127:0] dout_a;
    logic         grants [6];
    int           g;

    initial begin
        dout_a = 128'hDEADBEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
        bus.req_valid_0 = 1'b1; bus.req_write_0 = 1'b0; bus.req_addr_0 = 32'h40; bus.req_wdata_0 = '0;
        bus.req_valid_1 = 1'b1; bus.req_write_1 = 1'b1; bus.req_addr_1 = 32'h999; bus.req_wdata_1 = '1;
        bus.mem_is_ready = 1'b0; bus.mem_is_output_valid = 1'b0; bus.mem_dout = '0;
        next();
        checking = 1'b1;
        next();
        settle();
        chkb("rst_ready_0", bus.req_ready_0, 1'b0);
        chkb("rst_ready_1", bus.req_ready_1, 1'b0);
        chkb("rst_busy", bus.busy, 1'b0);
        chkb("rst_miv", bus.mem_is_input_valid, 1'b0);
        chkb("rst_resp_1", bus.resp_valid_1, 1'b0);
        next();
        reset = 1'b1;
        settle();
        chkb("first_tie_0", bus.req_ready_0, 1'b1);
        chkb("first_tie_1", bus.req_ready_1, 1'b0);
        next();
        bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0; bus.mem_is_ready = 1'b1;
        bus.req_addr_0 = 32'h1234;
        settle();
        chk("rd_addr", 128'(bus.mem_addr), 128'h40);
        chkb("rd_read", bus.mem_read, 1'b1);
        chkb("rd_miv", bus.mem_is_input_valid, 1'b1);
        next();
        bus.mem_is_ready = 1'b0;
        settle();
        chkb("rd_wait_miv", bus.mem_is_input_valid, 1'b0);
        next();
        next();
        bus.mem_is_output_valid = 1'b1; bus.mem_dout = dout_a;
        next();
        bus.mem_is_output_valid = 1'b0; bus.mem_dout = '0;
        settle();
        chkb("rd_resp_0", bus.resp_valid_0, 1'b1);
        chk("rd_data_0", bus.resp_rdata_0, dout_a);
        chkb("rd_resp_1", bus.resp_valid_1, 1'b0);
        next();
        settle();
        chkb("rd_resp_gone", bus.resp_valid_0, 1'b0);
        chkb("rd_idle", bus.busy, 1'b0);
        next();
        bus.req_valid_1 = 1'b1; bus.req_write_1 = 1'b1; bus.req_addr_1 = 32'h80;
        bus.req_wdata_1 = 128'h5555_AAAA_5555_AAAA_1234_5678_9ABC_DEF0;
        settle();
        chkb("wr_ready_1", bus.req_ready_1, 1'b1);
        next();
        bus.req_valid_1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chkb("wr_hold_miv", bus.mem_is_input_valid, 1'b1);
            chkb("wr_hold_write", bus.mem_write, 1'b1);
            chk("wr_hold_addr", 128'(bus.mem_addr), 128'h80);
            next();
        end
        bus.mem_is_ready = 1'b1;
        settle();
        chkb("wr_last_miv", bus.mem_is_input_valid, 1'b1);
        next();
        bus.mem_is_ready = 1'b0;
        settle();
        chkb("wr_resp_1", bus.resp_valid_1, 1'b1);
        chk("wr_data_1", bus.resp_rdata_1, 128'd0);
        chkb("wr_resp_0", bus.resp_valid_0, 1'b0);
        next();
        bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
        bus.req_write_0 = 1'b1; bus.req_write_1 = 1'b1; bus.mem_is_ready = 1'b1;
        g = 0;
        for (int c = 0; c < 40 && g < 6; c++) begin
            settle();
            if (bus.req_ready_0 || bus.req_ready_1) begin
                grants[g] = bus.req_ready_1;
                g++;
            end
            next();
        end
        bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
        chk("alt_count", 128'(g), 128'd6);
        for (int i = 0; i < 6; i++) chkb("alt_grant", grants[i], i[0]);
        for (int i = 0; i < 4; i++) next();
        bus.mem_is_ready = 1'b0;
        bus.req_valid_1 = 1'b1; bus.req_write_1 = 1'b0; bus.req_addr_1 = 32'h100;
        settle();
        chkb("wr_rst_ready_1", bus.req_ready_1, 1'b1);
        next();
        bus.req_valid_1 = 1'b0; bus.mem_is_ready = 1'b1;
        next();
        bus.mem_is_ready = 1'b0;
        settle();
        chkb("wait_busy", bus.busy, 1'b1);
        next();
        reset = 1'b0;
        next();
        reset = 1'b1; bus.mem_is_output_valid = 1'b1;
        settle();
        chkb("rst_wait_busy", bus.busy, 1'b0);
        chkb("rst_wait_resp", bus.resp_valid_1, 1'b0);
        next();
        bus.mem_is_output_valid = 1'b0; bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
        settle();
        chkb("late_ov_resp", bus.resp_valid_1, 1'b0);
        chkb("rst_tie_0", bus.req_ready_0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            next();
            reset = $urandom_range(99) != 0;
            bus.req_valid_0 = $urandom_range(2) != 0;
            bus.req_valid_1 = $urandom_range(2) != 0;
            bus.req_write_0 = $urandom_range(1) != 0;
            bus.req_write_1 = $urandom_range(1) != 0;
            bus.req_addr_0 = $urandom;
            bus.req_addr_1 = $urandom;
            bus.req_wdata_0 = {$urandom, $urandom, $urandom, $urandom};
            bus.req_wdata_1 = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_is_ready = $urandom_range(1) != 0;
            bus.mem_is_output_valid = $urandom_range(2) == 0;
            bus.mem_dout = {$urandom, $urandom, $urandom, $urandom};
        end
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
